fp32_to_int_converter: RTL

- Iterative IEEE-754 single-precision to signed two's-complement integer converter.
- Sits downstream of the IEEE754_Adder datapath and decodes packed float results into integer form for fixed-point consumers.
- One shift per clock; valid/ready handshakes on both sides; one conversion in flight at a time.

---
 rtl/fp32_to_int_converter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fp32_to_int_converter.sv
// Iterative IEEE-754 single to signed INT_W-bit integer converter, one shift per clock.
// Optional macro FP32_TO_INT_ROUND_NEAREST_EN selects round-half-to-even instead of truncation.
module fp32_to_int_converter #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        SHIFT  = 3'd2,
        PACK   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic signed [10:0] EMAX_S = 11'(INT_W - 1);
`ifdef FP32_TO_INT_ROUND_NEAREST_EN
    localparam logic signed [10:0] EMIN_S = -11'sd1;
`else
    localparam logic signed [10:0] EMIN_S = 11'sd0;
`endif

    state_t            state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [INT_W-1:0]  out_data_r;
    logic              out_invalid_r;
    logic              out_inexact_r;
    logic [31:0]       data_r;
    logic [INT_W-1:0]  mag_r;
    logic [5:0]        cnt_r;
    logic              left_r;
    logic              guard_r;
    logic              sticky_r;
    logic              sign_r;
    logic              inv_r;

    logic [7:0]        exp_s;
    logic [22:0]       mant_s;
    logic signed [10:0] e_s;
    logic              dec_special_s;
    logic              dec_inv_s;
    logic [INT_W-1:0]  dec_mag_s;
    logic              dec_sign_s;
    logic              dec_sticky_s;
    logic              dec_left_s;
    logic [5:0]        dec_cnt_s;
    logic [INT_W-1:0]  mag_fin_s;

    // Saturated magnitude; the negative bound is 2^(INT_W-1), which negates onto itself.
    function automatic logic [INT_W-1:0] sat_mag(input logic neg);
        if (neg) begin
            return {1'b1, {(INT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(INT_W-1){1'b1}}};
        end
    endfunction

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_invalid = out_invalid_r;
    assign out_inexact = out_inexact_r;

    // Classify the latched float and prepare the magnitude register and shift count.
    always_comb begin
        exp_s         = data_r[30:23];
        mant_s        = data_r[22:0];
        e_s           = $signed({3'b000, exp_s}) - 11'sd127;
        dec_special_s = 1'b0;
        dec_inv_s     = 1'b0;
        dec_mag_s     = INT_W'({1'b1, mant_s});
        dec_sign_s    = data_r[31];
        dec_sticky_s  = 1'b0;
        dec_left_s    = 1'b0;
        dec_cnt_s     = 6'd0;
        if (exp_s == 8'hFF) begin
            dec_special_s = 1'b1;
            dec_inv_s     = 1'b1;
            if (mant_s != 23'd0) begin
                dec_mag_s  = {INT_W{1'b0}};
                dec_sign_s = 1'b0;
            end else begin
                dec_mag_s = sat_mag(data_r[31]);
            end
        end else if ((e_s > EMAX_S) ||
                     ((e_s == EMAX_S) && !(data_r[31] && (mant_s == 23'd0)))) begin
            dec_special_s = 1'b1;
            dec_inv_s     = 1'b1;
            dec_mag_s     = sat_mag(data_r[31]);
        end else if (e_s < EMIN_S) begin
            dec_special_s = 1'b1;
            dec_mag_s     = {INT_W{1'b0}};
            dec_sticky_s  = (exp_s != 8'd0) || (mant_s != 23'd0);
        end else if (e_s >= 11'sd23) begin
            dec_left_s = 1'b1;
            dec_cnt_s  = 6'(e_s - 11'sd23);
        end else begin
            dec_left_s = 1'b0;
            dec_cnt_s  = 6'(11'sd23 - e_s);
        end
    end

`ifdef FP32_TO_INT_ROUND_NEAREST_EN
    logic round_up_s;

    // Half-to-even increment from the guard/sticky pair; cannot overflow since e < 23 here.
    always_comb begin
        round_up_s = guard_r & (sticky_r | mag_r[0]);
        mag_fin_s  = mag_r + INT_W'(round_up_s);
    end
`else
    // Truncation toward zero: the magnitude is used as shifted.
    always_comb begin
        mag_fin_s = mag_r;
    end
`endif

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= {INT_W{1'b0}};
            out_invalid_r <= 1'b0;
            out_inexact_r <= 1'b0;
            data_r        <= 32'd0;
            mag_r         <= {INT_W{1'b0}};
            cnt_r         <= 6'd0;
            left_r        <= 1'b0;
            guard_r       <= 1'b0;
            sticky_r      <= 1'b0;
            sign_r        <= 1'b0;
            inv_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        data_r     <= in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= DECODE;
                    end
                end
                DECODE: begin
                    mag_r    <= dec_mag_s;
                    sign_r   <= dec_sign_s;
                    inv_r    <= dec_inv_s;
                    guard_r  <= 1'b0;
                    sticky_r <= dec_sticky_s;
                    left_r   <= dec_left_s;
                    cnt_r    <= dec_cnt_s;
                    if (dec_special_s || (dec_cnt_s == 6'd0)) begin
                        state_r <= PACK;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (left_r) begin
                        mag_r <= {mag_r[INT_W-2:0], 1'b0};
                    end else begin
                        // Guard holds the most recent bit shifted out; older ones collapse into sticky.
                        mag_r    <= {1'b0, mag_r[INT_W-1:1]};
                        guard_r  <= mag_r[0];
                        sticky_r <= sticky_r | guard_r;
                    end
                    cnt_r <= cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        state_r <= PACK;
                    end
                end
                PACK: begin
                    out_data_r    <= sign_r ? (-mag_fin_s) : mag_fin_s;
                    out_inexact_r <= guard_r | sticky_r;
                    out_invalid_r <= inv_r;
                    out_valid_r   <= 1'b1;
                    state_r       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
